uart_tx_fifo: RTL and testbench

- Buffered 8N1 UART transmitter for the Z80 host.
- Sits between the CPU I/O-write decode (upstream) and the UART_TXD board pin (downstream).
- The CPU writes bytes into a small FIFO; a baud-timed shifter serialises them LSB-first onto txd.
- Runs on the divided CPU clock, 2.5 MHz nominal.

---
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small write FIFO fed by the CPU I/O decode,
// drained by a baud-timed shifter that drives txd LSB-first from a register.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 22,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [7:0]         wr_data,
    input  logic               wr_en,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   level,
    output logic               overflow,
    input  logic               ovf_clr,
    output logic               tx_busy,
    output logic               txd
);

    localparam int          DEPTH    = 1 << FIFO_AW;
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic [FIFO_AW:0] r_level;
    logic             r_full;
    logic             r_empty;
    logic             r_ovf;

    // Shifter state
    state_t           r_state;
    logic [15:0]      r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_txd;
    logic             r_busy;

    // Next-state wires
    logic             w_push;
    logic             w_pop;
    logic [FIFO_AW:0] w_wr_ptr_nxt;
    logic [FIFO_AW:0] w_rd_ptr_nxt;
    logic [FIFO_AW:0] w_level_nxt;
    state_t           w_state_nxt;
    logic [15:0]      w_baud_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_txd_nxt;

    // Full is judged on the pre-edge occupancy, so a same-edge pop never frees room
    assign w_push       = wr_en & ~r_full;
    assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + {{FIFO_AW{1'b0}}, 1'b1}) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + {{FIFO_AW{1'b0}}, 1'b1}) : r_rd_ptr;
    assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign overflow = r_ovf;
    assign tx_busy  = r_busy;
    assign txd      = r_txd;

    // FIFO data array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= wr_data;
        end
    end

    // FIFO pointers, registered occupancy flags and sticky overflow
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == (FIFO_AW+1)'(DEPTH));
            r_empty  <= (w_level_nxt == '0);
            if (wr_en && r_full) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Shifter next-state logic: baud counting, bit sequencing and FIFO pop
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = 16'd0;
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr[FIFO_AW-1:0]];
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_baud == LAST_CNT) begin
                    w_baud_nxt  = 16'd0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            ST_DATA: begin
                if (r_baud == LAST_CNT) begin
                    w_baud_nxt  = 16'd0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            ST_STOP: begin
                if (r_baud == LAST_CNT) begin
                    w_baud_nxt  = 16'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: begin
                w_baud_nxt  = 16'd0;
                w_bit_nxt   = 3'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, decoded from the next state so txd is a clean flop
    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            ST_START: w_txd_nxt = 1'b0;
            ST_DATA:  w_txd_nxt = w_shift_nxt[0];
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    // Shifter state register; reset aborts any frame and parks the line high
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= ST_IDLE;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_txd     <= w_txd_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a queue-level reference model predicts
// FIFO occupancy and frame start times; a serial monitor decodes txd frames
// and compares them against the bytes the model says were popped.
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          nreset;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          ovf_clr;
    logic          tx_busy;
    logic          txd;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    int         m_busy = 0;
    logic       m_ovf  = 1'b0;
    int         cyc    = 0;
    logic [7:0] exp_byte[$];
    int         exp_cyc[$];
    logic       frame_abort = 1'b0;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
        .clk(clk), .nreset(nreset), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .ovf_clr(ovf_clr), .tx_busy(tx_busy), .txd(txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wr(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (!(m_busy == 0 && m_q.size() == 0 && exp_byte.size() == 0) && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_done", int'(m_busy == 0 && m_q.size() == 0 && exp_byte.size() == 0), 1);
    endtask

    // Reference model: a frame occupies the line for 10*C cycles after its pop,
    // and a pop is only possible once the line has been free for a cycle
    initial begin
        forever begin
            @(posedge clk or negedge nreset);
            if (!nreset) begin
                m_q.delete();
                m_busy = 0;
                m_ovf  = 1'b0;
                if (clk) cyc++;
            end else begin
                bit was_full;
                bit do_pop;
                cyc++;
                was_full = (m_q.size() == DEPTH);
                do_pop   = (m_busy == 0) && (m_q.size() > 0);
                if (wr_en && was_full) m_ovf = 1'b1;
                else if (ovf_clr) m_ovf = 1'b0;
                if (m_busy > 0) m_busy--;
                if (do_pop) begin
                    exp_byte.push_back(m_q.pop_front());
                    exp_cyc.push_back(cyc);
                    m_busy = 10 * C;
                end
                if (wr_en && !was_full) m_q.push_back(wr_data);
            end
        end
    end

    // Per-cycle status comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("level", int'(level), m_q.size());
            check("full", int'(full), int'(m_q.size() == DEPTH));
            check("empty", int'(empty), int'(m_q.size() == 0));
            check("overflow", int'(overflow), int'(m_ovf));
            check("tx_busy", int'(tx_busy), int'(m_busy > 0));
            if (m_busy == 0) check("idle_txd", int'(txd), 1);
        end
    end

    // Serial monitor: decode each frame mid-bit and score it
    initial begin
        logic       prev = 1'b1;
        logic [7:0] b;
        logic       st_bit;
        logic       sp_bit;
        int         s_cyc;
        forever begin
            @(negedge clk);
            if (nreset && prev && !txd) begin
                s_cyc = cyc;
                repeat (C/2) @(negedge clk);
                st_bit = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = txd;
                end
                repeat (C) @(negedge clk);
                sp_bit = txd;
                if (frame_abort) begin
                    frame_abort = 1'b0;
                end else if (exp_byte.size() == 0) begin
                    check("unexpected_frame", int'(b), -1);
                end else begin
                    check("frame_byte", int'(b), int'(exp_byte.pop_front()));
                    check("frame_start_cycle", s_cyc, exp_cyc.pop_front());
                    check("start_bit", int'(st_bit), 0);
                    check("stop_bit", int'(sp_bit), 1);
                end
            end
            prev = txd;
        end
    end

    // Directed scenarios followed by a randomized phase
    initial begin
        int n;
        nreset  = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        check("rst_txd", int'(txd), 1);
        check("rst_empty", int'(empty), 1);
        check("rst_level", int'(level), 0);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_ovf", int'(overflow), 0);
        @(posedge clk);
        #1;

        // Single byte: start bit appears on the edge after the write
        wr(8'hA5);
        @(negedge clk);
        check("single_empty_after_wr", int'(empty), 0);
        @(negedge clk);
        check("single_start_txd", int'(txd), 0);
        @(posedge clk);
        #1;
        wait_idle(200);

        // Back-to-back bytes
        wr(8'h00);
        wr(8'hFF);
        wait_idle(300);

        // Fill and overflow with one byte in flight
        wr(8'h3C);
        for (int k = 0; k < 5; k++) wr(8'($urandom));
        @(negedge clk);
        check("fill_full", int'(full), 1);
        check("fill_level", int'(level), 4);
        check("fill_ovf", int'(overflow), 1);
        @(posedge clk);
        #1 ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", int'(overflow), 0);
        @(posedge clk);
        #1;

        // Write arriving on the same edge as a pop from a full FIFO
        n = 0;
        while (!(m_busy == 0 && m_q.size() == DEPTH) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pop_at_full_reached", int'(n < 200), 1);
        wr(8'h99);
        @(negedge clk);
        check("pop_at_full_ovf", int'(overflow), 1);
        check("pop_at_full_level", int'(level), 3);
        @(posedge clk);
        #1;
        wait_idle(400);

        // Randomized traffic with varying write density and clear pulses
        for (int seg = 0; seg < 10; seg++) begin
            int rate;
            rate = int'($urandom_range(1, 40));
            for (int i = 0; i < 300; i++) begin
                wr_en   = ($urandom_range(0, rate - 1) == 0);
                wr_data = 8'($urandom);
                ovf_clr = ($urandom_range(0, 15) == 0);
                @(posedge clk);
                #1;
            end
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        wait_idle(1000);

        // Reset during data bit 3
        wr(8'h5A);
        repeat (17) @(posedge clk);
        #3;
        frame_abort = 1'b1;
        nreset      = 1'b0;
        exp_byte.delete();
        exp_cyc.delete();
        #1;
        check("midrst_txd", int'(txd), 1);
        check("midrst_empty", int'(empty), 1);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("post_rst_quiet", int'(txd), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
